ad_ip_jesd204_tpl_dac_stream_buf: RTL and testbench
===================================================

Name: ad_ip_jesd204_tpl_dac_stream_buf

Overview:
- Upstream feeder for the JESD204 transport-layer DAC.
- Accepts AXI-Stream sample beats from the DMA and buffers them in a FIFO with prefill.
- Delivers one beat of dac_ddata for each dac_valid request from the TPL core, in the link clock domain.
- Flags dac_dunf when the TPL requests data that the buffer cannot supply.

Parameters:
- NUM_CHANNELS, 2, number of converter channels; width of enable/dac_valid.
- DATA_WIDTH, 128, beat width; must equal the TPL link data width (NUM_LANES*8*OCTETS_PER_BEAT).
- ADDRESS_WIDTH, 4, FIFO depth DEPTH = 2**ADDRESS_WIDTH beats.
- START_THRESHOLD, 8, fill level required before streaming starts; legal range 1..DEPTH.

Ports:
- clk  in  1  link clock (line-rate/40), the only clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  NUM_CHANNELS  per-channel enable from the TPL core.
- dac_valid  in  NUM_CHANNELS  per-channel data request from the TPL core; a beat is consumed when any bit is high.
- dac_ddata  out  DATA_WIDTH  sample beat to the TPL core.
- dac_dunf  out  1  underflow pulse.
- s_axis_valid  in  1  DMA beat valid.
- s_axis_ready  out  1  buffer accepts a beat.
- s_axis_data  in  DATA_WIDTH  DMA beat data.
- s_axis_last  in  1  last beat of the DMA transfer.
- fill_level  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE.
  - Pointers and count = 0.
  - dac_ddata = 0, dac_dunf = 0.
  - s_axis_ready = 0, fill_level = 0.
- Definitions:
  - push = s_axis_valid & s_axis_ready.
  - beat = |dac_valid.
- s_axis_ready is combinational: (state != IDLE) & (count != DEPTH). It never depends on s_axis_valid.
- State machine:
  - IDLE:
    - FIFO held empty; pointers and count forced to 0.
    - dac_ddata <= 0; no dunf.
    - Goes to FILL when |enable.
  - FILL:
    - Pushes accepted; beats do not pop.
    - A beat in FILL drives dac_ddata <= 0 with dac_dunf = 0 (stream not yet started).
    - Goes to RUN when count_next >= START_THRESHOLD, or when a push carries s_axis_last (short transfer).
  - RUN:
    - Pushes and pops active.
    - Stays in RUN until enable == 0.
  - Any state: enable == 0 forces IDLE on the next edge and flushes the FIFO. This includes mid-transfer and mid-underflow.
- Read path in RUN, registered with latency 1 (data appears the cycle after the beat):
  - beat & count > 0: dac_ddata <= mem[rd_ptr]; rd_ptr++; dac_dunf <= 0.
  - beat & count == 0: dac_ddata <= 0; dac_dunf <= 1. The pulse lasts one cycle per underflowed beat.
  - No beat: dac_ddata holds its value; dac_dunf <= 0.
- Write path: on push, mem[wr_ptr] <= s_axis_data; wr_ptr++.
- Pointers wrap modulo DEPTH.
- Count update:
  - count_next = count + push - pop, where pop = RUN & beat & (count > 0).
  - Push and pop in the same cycle leave count unchanged.
- Boundary cases:
  - count == 0 with push and beat in the same cycle: underflow (no bypass); count becomes 1.
  - Full buffer: ready = 0, so push and pop can never coincide at DEPTH. A pop from full re-asserts ready on the next cycle.
- fill_level = count (registered). It is never observed above DEPTH or below 0.
- s_axis_last affects only the FILL->RUN decision; it is not stored.

Test Plan:
- Reset then enable=2'b11, push 8 beats D0..D7 (threshold 8) -> FILL->RUN on the 8th push; beats issued before that return 0 with no dunf; next beat returns D0 one cycle later, fill_level 8->7.
- RUN with 16 beats pushed, no DMA valid, dac_valid held high for 18 cycles -> dac_ddata D0..D15 in order, then two cycles of 0 with dac_dunf high; fill_level reaches 0.
- Push 16 beats with dac_valid=0 -> s_axis_ready drops after the 16th push, fill_level=16; one beat -> ready=1 next cycle; wrap-around verified by pushing and popping 40 beats with a data-integrity check.
- Simultaneous push and beat at count 0 in RUN -> dac_dunf=1, dac_ddata=0, fill_level becomes 1; next beat returns the pushed word.
- 3-beat transfer with s_axis_last on the 3rd beat -> RUN entered below threshold; 3 beats delivered, 4th underflows.
- enable dropped mid-RUN with fill_level=5 -> IDLE next cycle, fill_level=0, s_axis_ready=0; re-enable -> FILL and a fresh prefill with no stale data.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_dac_stream_buf.sv
// ad_ip_jesd204_tpl_dac_stream_buf
//
// Feeds sample beats from the DMA (AXI-Stream) into the JESD204 transport
// layer DAC. Beats are buffered in a FIFO. Streaming starts only after a prefill
// level is reached, or earlier when a short transfer ends. After that, each
// dac_valid request from the TPL core pops one beat. A request the buffer
// cannot serve returns zero and raises dac_dunf for one cycle.
//
// Ports
//   clk           link clock, the only clock
//   resetn        asynchronous active-low reset
//   enable        per-channel enable; all-zero returns to IDLE and flushes
//   dac_valid     per-channel data request; any bit high consumes a beat
//   dac_ddata     sample beat to the TPL core, one cycle after the request
//   dac_dunf      underflow pulse, one cycle per unserved request
//   s_axis_valid  DMA beat valid
//   s_axis_ready  buffer can accept a beat (independent of s_axis_valid)
//   s_axis_data   DMA beat data
//   s_axis_last   last beat of a DMA transfer (only ends prefill early)
//   fill_level    current FIFO occupancy, 0..DEPTH
module ad_ip_jesd204_tpl_dac_stream_buf #(
  parameter int NUM_CHANNELS    = 2,
  parameter int DATA_WIDTH      = 128,
  parameter int ADDRESS_WIDTH   = 4,
  parameter int START_THRESHOLD = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_CHANNELS-1:0]   enable,
  input  logic [NUM_CHANNELS-1:0]   dac_valid,
  output logic [DATA_WIDTH-1:0]     dac_ddata,
  output logic                      dac_dunf,
  input  logic                      s_axis_valid,
  output logic                      s_axis_ready,
  input  logic [DATA_WIDTH-1:0]     s_axis_data,
  input  logic                      s_axis_last,
  output logic [ADDRESS_WIDTH:0]    fill_level
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_C  = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] THRESH_C = (ADDRESS_WIDTH + 1)'(START_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic [ADDRESS_WIDTH:0]   w_count_next;
  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    r_ddata_p1;
  logic                     r_dunf_p1;

  logic w_en;
  logic w_beat;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_flush;

  assign w_en    = |enable;
  assign w_beat  = |dac_valid;
  assign w_ready = (r_state != IDLE) && (r_count != DEPTH_C);
  assign w_push  = s_axis_valid & w_ready;
  // A request at count 0 underflows even if a push lands in the same cycle:
  // there is no write-to-read bypass.
  assign w_pop   = (r_state == RUN) & w_beat & (r_count != '0);
  // IDLE keeps the FIFO empty; dropping enable empties it from any state.
  assign w_flush = !w_en || (r_state == IDLE);

  assign w_count_next = r_count + (ADDRESS_WIDTH + 1)'(w_push)
                                - (ADDRESS_WIDTH + 1)'(w_pop);

  always_comb begin
    w_state_next = r_state;
    if (!w_en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_next = FILL;
        // Short transfers start streaming at their last beat even if the
        // prefill level has not been reached.
        FILL: if (w_push && ((w_count_next >= THRESH_C) || s_axis_last))
                w_state_next = RUN;
        RUN:  w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FIFO storage is not reset: the pointers and the count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_axis_data;
    end
  end

  // ---- stage p1: pointer/count update and registered read beat ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ddata_p1 <= '0;
      r_dunf_p1  <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ddata_p1 <= '0;
      r_dunf_p1  <= 1'b0;
    end else begin
      // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= w_count_next;
      r_dunf_p1 <= 1'b0;
      if (w_beat) begin
        if (r_state != RUN) begin
          // Requests during prefill return silence and are not underflows.
          r_ddata_p1 <= '0;
        end else if (r_count != '0) begin
          r_ddata_p1 <= r_mem[r_rd_ptr];
        end else begin
          r_ddata_p1 <= '0;
          r_dunf_p1  <= 1'b1;
        end
      end
    end
  end

  assign dac_ddata    = r_ddata_p1;
  assign dac_dunf     = r_dunf_p1;
  assign s_axis_ready = w_ready;
  assign fill_level   = r_count;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_stream_buf.sv
module tb_ad_ip_jesd204_tpl_dac_stream_buf;

  localparam int NCH   = 2;
  localparam int DW    = 128;
  localparam int AW    = 4;
  localparam int TH    = 8;
  localparam int DEPTH = 16;

  localparam logic [1:0] EN = 2'b11;
  localparam logic [1:0] NO = 2'b00;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_RUN  = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] dac_valid;
  logic [DW-1:0]  dac_ddata;
  logic           dac_dunf;
  logic           s_axis_valid;
  logic           s_axis_ready;
  logic [DW-1:0]  s_axis_data;
  logic           s_axis_last;
  logic [AW:0]    fill_level;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue-based FIFO, state, and last delivered word.
  logic [DW-1:0] m_fifo [$];
  logic [DW:0]   exp_q  [$];
  int            m_state = M_IDLE;
  logic [DW-1:0] m_ddata = '0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_stream_buf #(
    .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .START_THRESHOLD(TH)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .dac_valid(dac_valid),
    .dac_ddata(dac_ddata), .dac_dunf(dac_dunf),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .fill_level(fill_level)
  );

  function automatic logic [DW-1:0] mk(input int tag, input int i);
    return {tag, i, ~tag, ~i};
  endfunction

  // One clock cycle: drive inputs, advance the model, then check the DUT's
  // outputs (scoreboard pop for requests, held value otherwise).
  task automatic step(input logic [1:0] en, input logic sv, input logic [DW-1:0] sd,
                      input logic sl, input logic [1:0] dv);
    logic       mready;
    logic       push;
    logic       beat;
    logic [DW:0] e;
    enable = en; s_axis_valid = sv; s_axis_data = sd; s_axis_last = sl; dac_valid = dv;
    mready = (m_state != M_IDLE) && (m_fifo.size() != DEPTH);
    n_checks++;
    if (s_axis_ready !== mready)
      $display("FAIL ready: got %b expected %b", s_axis_ready, mready);
    else n_pass++;
    push = sv & mready;
    beat = |dv;
    if (en == 2'b00) begin
      m_fifo.delete();
      m_state = M_IDLE;
      m_ddata = '0;
      if (beat) exp_q.push_back('0);
    end else begin
      case (m_state)
        M_IDLE: begin
          m_ddata = '0;
          m_state = M_FILL;
          if (beat) exp_q.push_back('0);
        end
        M_FILL: begin
          if (push) m_fifo.push_back(sd);
          if (beat) begin
            m_ddata = '0;
            exp_q.push_back('0);
          end
          if (push && ((m_fifo.size() >= TH) || sl)) m_state = M_RUN;
        end
        default: begin
          if (beat) begin
            if (m_fifo.size() > 0) begin
              m_ddata = m_fifo.pop_front();
              exp_q.push_back({1'b0, m_ddata});
            end else begin
              m_ddata = '0;
              exp_q.push_back({1'b1, {DW{1'b0}}});
            end
          end
          if (push) m_fifo.push_back(sd);
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (beat) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({dac_dunf, dac_ddata} !== e)
        $display("FAIL beat: got dunf=%b data=%h expected dunf=%b data=%h",
                 dac_dunf, dac_ddata, e[DW], e[DW-1:0]);
      else n_pass++;
    end else begin
      n_checks++;
      if (dac_dunf !== 1'b0 || dac_ddata !== m_ddata)
        $display("FAIL hold: got dunf=%b data=%h expected dunf=0 data=%h",
                 dac_dunf, dac_ddata, m_ddata);
      else n_pass++;
    end
    n_checks++;
    if (fill_level !== (AW+1)'(m_fifo.size()))
      $display("FAIL fill_level: got %0d expected %0d", fill_level, m_fifo.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = '0; dac_valid = '0;
    s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dac_ddata !== '0) $display("FAIL rst_ddata: got %h expected 0", dac_ddata); else n_pass++;
    n_checks++;
    if (dac_dunf !== 1'b0) $display("FAIL rst_dunf: got %b expected 0", dac_dunf); else n_pass++;
    n_checks++;
    if (s_axis_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", s_axis_ready); else n_pass++;
    n_checks++;
    if (fill_level !== '0) $display("FAIL rst_fill: got %0d expected 0", fill_level); else n_pass++;
    resetn = 1'b1;
    step(NO, 1'b1, mk(9, 9), 1'b0, NO);
  endtask

  task automatic test_prefill();
    step(EN, 1'b0, '0, 1'b0, NO);
    for (int i = 0; i < 8; i++)
      step(EN, 1'b1, mk(1, i), 1'b0, (i == 2 || i == 5) ? EN : NO);
    n_checks++;
    if (fill_level !== 5'd8) $display("FAIL prefill_level: got %0d expected 8", fill_level); else n_pass++;
    step(EN, 1'b0, '0, 1'b0, EN);
    n_checks++;
    if (dac_ddata !== mk(1, 0)) $display("FAIL prefill_first: got %h expected %h", dac_ddata, mk(1, 0)); else n_pass++;
    n_checks++;
    if (fill_level !== 5'd7) $display("FAIL prefill_pop: got %0d expected 7", fill_level); else n_pass++;
  endtask

  task automatic test_drain();
    step(NO, 1'b0, '0, 1'b0, NO);
    step(EN, 1'b0, '0, 1'b0, NO);
    for (int i = 0; i < 16; i++) step(EN, 1'b1, mk(2, i), 1'b0, NO);
    for (int i = 0; i < 18; i++) begin
      step(EN, 1'b0, '0, 1'b0, EN);
      if (i == 15) begin
        n_checks++;
        if (dac_ddata !== mk(2, 15)) $display("FAIL drain_last: got %h expected %h", dac_ddata, mk(2, 15)); else n_pass++;
      end
      if (i >= 16) begin
        n_checks++;
        if (dac_dunf !== 1'b1 || dac_ddata !== '0)
          $display("FAIL drain_dunf: got dunf=%b data=%h expected dunf=1 data=0", dac_dunf, dac_ddata);
        else n_pass++;
      end
    end
    n_checks++;
    if (fill_level !== '0) $display("FAIL drain_level: got %0d expected 0", fill_level); else n_pass++;
  endtask

  task automatic test_full_wrap();
    step(NO, 1'b0, '0, 1'b0, NO);
    step(EN, 1'b0, '0, 1'b0, NO);
    for (int i = 0; i < 16; i++) step(EN, 1'b1, mk(3, i), 1'b0, NO);
    n_checks++;
    if (s_axis_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", s_axis_ready); else n_pass++;
    n_checks++;
    if (fill_level !== 5'd16) $display("FAIL full_level: got %0d expected 16", fill_level); else n_pass++;
    step(EN, 1'b1, mk(3, 99), 1'b0, NO);
    step(EN, 1'b0, '0, 1'b0, EN);
    n_checks++;
    if (s_axis_ready !== 1'b1) $display("FAIL unfull_ready: got %b expected 1", s_axis_ready); else n_pass++;
    for (int i = 0; i < 40; i++)
      step(EN, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, EN);
    for (int i = 0; i < 15; i++) step(EN, 1'b0, '0, 1'b0, EN);
  endtask

  task automatic test_simul_underflow();
    step(EN, 1'b1, mk(4, 1), 1'b0, EN);
    n_checks++;
    if (dac_dunf !== 1'b1 || dac_ddata !== '0)
      $display("FAIL simul_dunf: got dunf=%b data=%h expected dunf=1 data=0", dac_dunf, dac_ddata);
    else n_pass++;
    n_checks++;
    if (fill_level !== 5'd1) $display("FAIL simul_level: got %0d expected 1", fill_level); else n_pass++;
    step(EN, 1'b0, '0, 1'b0, EN);
    n_checks++;
    if (dac_ddata !== mk(4, 1) || dac_dunf !== 1'b0)
      $display("FAIL simul_next: got dunf=%b data=%h expected dunf=0 data=%h", dac_dunf, dac_ddata, mk(4, 1));
    else n_pass++;
  endtask

  task automatic test_short_last();
    step(NO, 1'b0, '0, 1'b0, NO);
    step(2'b01, 1'b0, '0, 1'b0, NO);
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, mk(5, i), (i == 2), NO);
    n_checks++;
    if (fill_level !== 5'd3) $display("FAIL short_level: got %0d expected 3", fill_level); else n_pass++;
    for (int i = 0; i < 4; i++) step(2'b01, 1'b0, '0, 1'b0, 2'b10);
    n_checks++;
    if (dac_dunf !== 1'b1) $display("FAIL short_dunf: got %b expected 1", dac_dunf); else n_pass++;
  endtask

  task automatic test_enable_drop();
    step(NO, 1'b0, '0, 1'b0, NO);
    step(EN, 1'b0, '0, 1'b0, NO);
    for (int i = 0; i < 8; i++) step(EN, 1'b1, mk(6, i), 1'b0, NO);
    for (int i = 0; i < 3; i++) step(EN, 1'b0, '0, 1'b0, EN);
    n_checks++;
    if (fill_level !== 5'd5) $display("FAIL drop_before: got %0d expected 5", fill_level); else n_pass++;
    step(NO, 1'b0, '0, 1'b0, NO);
    n_checks++;
    if (fill_level !== '0) $display("FAIL drop_level: got %0d expected 0", fill_level); else n_pass++;
    n_checks++;
    if (s_axis_ready !== 1'b0) $display("FAIL drop_ready: got %b expected 0", s_axis_ready); else n_pass++;
    step(EN, 1'b0, '0, 1'b0, NO);
    n_checks++;
    if (s_axis_ready !== 1'b1) $display("FAIL reen_ready: got %b expected 1", s_axis_ready); else n_pass++;
    for (int i = 0; i < 8; i++) step(EN, 1'b1, mk(7, i), 1'b0, (i == 0) ? EN : NO);
    step(EN, 1'b0, '0, 1'b0, EN);
    n_checks++;
    if (dac_ddata !== mk(7, 0)) $display("FAIL reen_data: got %h expected %h", dac_ddata, mk(7, 0)); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_prefill();
    test_drain();
    test_full_wrap();
    test_simul_underflow();
    test_short_last();
    test_enable_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
